// File: rtl/diaosi_types_pkg.sv
// diaosi_types_pkg: shared PC source and fetch state encodings
package diaosi_types_pkg;
    typedef enum logic [1:0] {
        PC_4  = 2'b00,
        PC_BR = 2'b01,
        PC_J  = 2'b10,
        PC_JR = 2'b11
    } PCSrc_t;

    typedef enum logic [1:0] {
        BOOT  = 2'b00,
        FETCH = 2'b01,
        IWAIT = 2'b10,
        HALT  = 2'b11
    } fetch_state_t;
endpackage

// File: rtl/sat_counter.sv
// sat_counter: up counter that sticks at all-ones, with synchronous clear
module sat_counter #(
    parameter int W = 32
) (
    input  logic         clk,
    input  logic         clr,
    input  logic         inc,
    output logic [W-1:0] q
);
    always_ff @(posedge clk)
        q <= clr ? '0 : (inc && !(&q)) ? q + 1'b1 : q;
endmodule

// File: rtl/pc_fetch_ctrl.sv
// pc_fetch_ctrl: PC update/source arbitration with memory and hazard stalls
module pc_fetch_ctrl
    import diaosi_types_pkg::*;
#(
    parameter int CNT_W = 32
) (
    input  logic             CLK,
    input  logic             rst,
    input  logic             ihit,
    input  logic             dmem_req,
    input  logic             dhit,
    input  logic             load_use_stall,
    input  logic             jump_req,
    input  logic             branch_taken,
    input  logic             jr_req,
    input  logic             halt,
    output logic             pc_next,
    output logic [1:0]       PCSrc,
    output logic             flush_ifid,
    output logic             flush_idex,
    output logic             iREN,
    output logic             halted,
    output logic [CNT_W-1:0] stall_cnt,
    output logic [CNT_W-1:0] redirect_cnt
);
    fetch_state_t state, state_n;
    PCSrc_t       src;
    logic         active, mem_block;

    assign active    = state == FETCH || state == IWAIT;
    assign mem_block = dmem_req && !dhit;
    // an EX redirect beats a load-use stall since the held ID instruction is wrong-path
    assign pc_next   = active && !halt && ihit && !mem_block &&
                       (!load_use_stall || jr_req || branch_taken);
    assign src       = !active      ? PC_4  :
                       jr_req       ? PC_JR :
                       branch_taken ? PC_BR :
                       jump_req     ? PC_J  : PC_4;
    assign PCSrc      = src;
    assign flush_ifid = pc_next && src != PC_4;
    assign flush_idex = pc_next && (src == PC_JR || src == PC_BR);
    assign iREN       = active;

    always_comb begin
        state_n = state;
        case (state)
            BOOT:    state_n = FETCH;
            FETCH:   state_n = halt ? HALT : !ihit ? IWAIT : FETCH;
            IWAIT:   state_n = halt ? HALT : ihit ? FETCH : IWAIT;
            default: state_n = HALT;
        endcase
    end

    always_ff @(posedge CLK) begin
        if (rst) begin
            state  <= BOOT;
            halted <= 1'b0;
        end else begin
            state  <= state_n;
            halted <= state_n == HALT;
        end
    end

    sat_counter #(.W(CNT_W)) u_stall_cnt (
        .clk (CLK),
        .clr (rst),
        .inc (active && !pc_next),
        .q   (stall_cnt)
    );

    sat_counter #(.W(CNT_W)) u_redirect_cnt (
        .clk (CLK),
        .clr (rst),
        .inc (flush_ifid),
        .q   (redirect_cnt)
    );
endmodule

// File: tb/tb_pc_fetch_ctrl.sv
// tb_pc_fetch_ctrl: directed scenario checks for pc_fetch_ctrl
module tb_pc_fetch_ctrl;
    logic        CLK = 1'b0;
    logic        rst, ihit, dmem_req, dhit, load_use_stall;
    logic        jump_req, branch_taken, jr_req, halt;
    logic        pc_next, flush_ifid, flush_idex, iREN, halted;
    logic [1:0]  PCSrc;
    logic [31:0] stall_cnt, redirect_cnt;
    int          errors = 0;
    int          checks = 0;

    always #5 CLK = ~CLK;

    pc_fetch_ctrl #(.CNT_W(32)) dut (
        .CLK            (CLK),
        .rst            (rst),
        .ihit           (ihit),
        .dmem_req       (dmem_req),
        .dhit           (dhit),
        .load_use_stall (load_use_stall),
        .jump_req       (jump_req),
        .branch_taken   (branch_taken),
        .jr_req         (jr_req),
        .halt           (halt),
        .pc_next        (pc_next),
        .PCSrc          (PCSrc),
        .flush_ifid     (flush_ifid),
        .flush_idex     (flush_idex),
        .iREN           (iREN),
        .halted         (halted),
        .stall_cnt      (stall_cnt),
        .redirect_cnt   (redirect_cnt)
    );

    task automatic step();
        @(posedge CLK);
        #1;
    endtask

    task automatic clear_inputs();
        ihit = 0; dmem_req = 0; dhit = 0; load_use_stall = 0;
        jump_req = 0; branch_taken = 0; jr_req = 0; halt = 0;
    endtask

    task automatic test_reset();
        rst = 1;
        clear_inputs();
        step();
        step();
        rst = 0;
        ihit = 1;
        #1;
        checks++; if (iREN !== 1'b0) begin errors++; $display("FAIL boot_iren got %b exp 0", iREN); end
        checks++; if (pc_next !== 1'b0) begin errors++; $display("FAIL boot_pc_next got %b exp 0", pc_next); end
        checks++; if (PCSrc !== 2'b00) begin errors++; $display("FAIL boot_pcsrc got %b exp 00", PCSrc); end
        checks++; if ({flush_ifid, flush_idex, halted} !== 3'b000) begin errors++; $display("FAIL boot_flags got %b exp 000", {flush_ifid, flush_idex, halted}); end
        checks++; if (stall_cnt !== 0 || redirect_cnt !== 0) begin errors++; $display("FAIL boot_cnts got %0d/%0d exp 0/0", stall_cnt, redirect_cnt); end
        step();
        for (int i = 0; i < 3; i++) begin
            checks++; if ({iREN, pc_next, PCSrc} !== 4'b1100) begin errors++; $display("FAIL seq_fetch[%0d] got iREN,pc_next,PCSrc=%b exp 1100", i, {iREN, pc_next, PCSrc}); end
            step();
        end
        checks++; if (stall_cnt !== 0) begin errors++; $display("FAIL seq_stall_cnt got %0d exp 0", stall_cnt); end
    endtask

    task automatic test_branch_iwait();
        ihit = 0;
        branch_taken = 1;
        for (int i = 0; i < 3; i++) begin
            #1;
            checks++; if ({iREN, pc_next, PCSrc, flush_ifid, flush_idex} !== 6'b100100) begin errors++; $display("FAIL iwait[%0d] got iREN,pc_next,PCSrc,fi,fe=%b exp 100100", i, {iREN, pc_next, PCSrc, flush_ifid, flush_idex}); end
            step();
        end
        checks++; if (stall_cnt !== 3) begin errors++; $display("FAIL iwait_stall_cnt got %0d exp 3", stall_cnt); end
        ihit = 1;
        #1;
        checks++; if ({pc_next, PCSrc, flush_ifid, flush_idex} !== 5'b10111) begin errors++; $display("FAIL iwait_release got %b exp 10111", {pc_next, PCSrc, flush_ifid, flush_idex}); end
        step();
        checks++; if (redirect_cnt !== 1 || stall_cnt !== 3) begin errors++; $display("FAIL iwait_cnts got %0d/%0d exp 1/3", redirect_cnt, stall_cnt); end
        branch_taken = 0;
    endtask

    task automatic test_priority();
        ihit = 1;
        jr_req = 1; branch_taken = 1; jump_req = 1;
        #1;
        checks++; if ({pc_next, PCSrc, flush_ifid, flush_idex} !== 5'b11111) begin errors++; $display("FAIL prio_jr got %b exp 11111", {pc_next, PCSrc, flush_ifid, flush_idex}); end
        step();
        jr_req = 0;
        #1;
        checks++; if ({pc_next, PCSrc, flush_ifid, flush_idex} !== 5'b10111) begin errors++; $display("FAIL prio_br_over_j got %b exp 10111", {pc_next, PCSrc, flush_ifid, flush_idex}); end
        step();
        branch_taken = 0;
        #1;
        checks++; if ({pc_next, PCSrc, flush_ifid, flush_idex} !== 5'b11010) begin errors++; $display("FAIL prio_j got %b exp 11010", {pc_next, PCSrc, flush_ifid, flush_idex}); end
        step();
        jump_req = 0;
        checks++; if (redirect_cnt !== 4) begin errors++; $display("FAIL prio_redirect_cnt got %0d exp 4", redirect_cnt); end
    endtask

    task automatic test_load_use();
        load_use_stall = 1;
        #1;
        checks++; if ({pc_next, PCSrc} !== 3'b000) begin errors++; $display("FAIL lu_stall got %b exp 000", {pc_next, PCSrc}); end
        step();
        branch_taken = 1;
        #1;
        checks++; if ({pc_next, PCSrc, flush_idex} !== 4'b1011) begin errors++; $display("FAIL lu_branch got %b exp 1011", {pc_next, PCSrc, flush_idex}); end
        step();
        branch_taken = 0;
        jump_req = 1;
        #1;
        checks++; if ({pc_next, PCSrc, flush_ifid} !== 4'b0100) begin errors++; $display("FAIL lu_jump got %b exp 0100", {pc_next, PCSrc, flush_ifid}); end
        step();
        checks++; if (stall_cnt !== 5 || redirect_cnt !== 5) begin errors++; $display("FAIL lu_cnts got %0d/%0d exp 5/5", stall_cnt, redirect_cnt); end
        load_use_stall = 0;
        jump_req = 0;
    endtask

    task automatic test_dmem();
        dmem_req = 1;
        dhit = 0;
        for (int i = 0; i < 2; i++) begin
            #1;
            checks++; if (pc_next !== 1'b0) begin errors++; $display("FAIL dmem_block[%0d] got %b exp 0", i, pc_next); end
            step();
        end
        checks++; if (stall_cnt !== 7) begin errors++; $display("FAIL dmem_stall_cnt got %0d exp 7", stall_cnt); end
        dhit = 1;
        #1;
        checks++; if ({pc_next, PCSrc} !== 3'b100) begin errors++; $display("FAIL dmem_release got %b exp 100", {pc_next, PCSrc}); end
        step();
        checks++; if (stall_cnt !== 7) begin errors++; $display("FAIL dmem_stall_after got %0d exp 7", stall_cnt); end
        dmem_req = 0;
        dhit = 0;
    endtask

    task automatic test_halt();
        halt = 1;
        jump_req = 1;
        #1;
        checks++; if ({pc_next, flush_ifid, flush_idex, halted} !== 4'b0000) begin errors++; $display("FAIL halt_cycle got %b exp 0000", {pc_next, flush_ifid, flush_idex, halted}); end
        step();
        halt = 0;
        checks++; if ({halted, iREN, pc_next} !== 3'b100) begin errors++; $display("FAIL halted got halted,iREN,pc_next=%b exp 100", {halted, iREN, pc_next}); end
        checks++; if (stall_cnt !== 8 || redirect_cnt !== 5) begin errors++; $display("FAIL halt_cnts got %0d/%0d exp 8/5", stall_cnt, redirect_cnt); end
        ihit = 1; jr_req = 1; branch_taken = 1; load_use_stall = 1;
        for (int i = 0; i < 3; i++) begin
            #1;
            checks++; if ({halted, iREN, pc_next, PCSrc, flush_ifid, flush_idex} !== 7'b1000000) begin errors++; $display("FAIL halt_frozen[%0d] got %b exp 1000000", i, {halted, iREN, pc_next, PCSrc, flush_ifid, flush_idex}); end
            step();
        end
        checks++; if (stall_cnt !== 8 || redirect_cnt !== 5) begin errors++; $display("FAIL halt_cnts_frozen got %0d/%0d exp 8/5", stall_cnt, redirect_cnt); end
        clear_inputs();
        rst = 1;
        step();
        rst = 0;
        checks++; if ({halted, iREN, pc_next} !== 3'b000 || stall_cnt !== 0 || redirect_cnt !== 0) begin errors++; $display("FAIL halt_reset got flags=%b cnts=%0d/%0d exp 000 0/0", {halted, iREN, pc_next}, stall_cnt, redirect_cnt); end
        ihit = 1;
        step();
        #1;
        checks++; if ({iREN, pc_next} !== 2'b11) begin errors++; $display("FAIL restart got %b exp 11", {iREN, pc_next}); end
    endtask

    initial begin
        test_reset();
        test_branch_iwait();
        test_priority();
        test_load_use();
        test_dmem();
        test_halt();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule

// File: doc/pc_fetch_ctrl.md
Name: pc_fetch_ctrl

Overview:
Fetch sequencer that drives the program counter's update enable (pc_next) and source select (PCSrc).
- Arbitrates between the sequential, jump, branch and jump-register requesters.
- Stalls the PC on instruction and data memory waits and on load-use hazards.
- Squashes wrong-path fetches and latches processor halt.
- Sits between the hazard/decode/execute logic and the program counter, and keeps saturating stall and redirect counters for performance debug.

Parameters:
CNT_W, 32, width of the stall_cnt and redirect_cnt performance counters.

Ports:
CLK  input  1  system clock, rising edge
rst  input  1  reset; synchronous, active-high
ihit  input  1  instruction memory returned the fetch this cycle
dmem_req  input  1  MEM stage has a dREN or dWEN access outstanding
dhit  input  1  data memory completed the access this cycle
load_use_stall  input  1  hazard unit holds the ID stage
jump_req  input  1  j/jal decoded in ID
branch_taken  input  1  beq/bne resolved taken in EX
jr_req  input  1  jr resolved in EX
halt  input  1  halt instruction reached commit
pc_next  output  1  PC update enable for this cycle
PCSrc  output  2  PCSrc_t select: PC_4=00, PC_BR=01, PC_J=10, PC_JR=11
flush_ifid  output  1  squash the IF/ID register
flush_idex  output  1  squash the ID/EX register
iREN  output  1  instruction read enable
halted  output  1  registered halt flag
stall_cnt  output  CNT_W  cycles lost in FETCH/IWAIT without a PC update
redirect_cnt  output  CNT_W  non-sequential PC updates taken

Behaviour:
- Clocking and reset:
  - One clock. rst is synchronous and active-high; it is sampled on the CLK edge and overrides everything.
  - After reset: state=BOOT, halted=0, counters=0, pc_next=0, PCSrc=PC_4, flush_ifid=flush_idex=0, iREN=0.
- State machine, states registered:
  - BOOT -> FETCH unconditionally after one cycle. In BOOT, iREN=0 and pc_next=0.
  - FETCH -> IWAIT when iREN=1 and ihit=0.
  - IWAIT -> FETCH when ihit=1.
  - FETCH or IWAIT -> HALT when halt=1. halt has priority over any concurrent redirect.
  - HALT is terminal until rst. In HALT: iREN=0, pc_next=0, flushes=0, counters frozen.
  - halted is a registered output: it reads 1 from the cycle after the state enters HALT.
- mem_block = dmem_req and not dhit. Data memory has priority over instruction memory on the shared port.
- redirect = jr_req or branch_taken or jump_req.
- pc_next (combinational, same cycle) = state is FETCH or IWAIT, and halt=0, and ihit=1, and mem_block=0, and (load_use_stall=0 or jr_req or branch_taken).
  - A redirect resolved in EX overrides a load-use stall, because the stalled ID instruction is wrong-path anyway.
- PCSrc priority (combinational): jr_req -> PC_JR, else branch_taken -> PC_BR, else jump_req -> PC_J, else PC_4.
  - The older EX redirect wins over an ID jump.
  - PCSrc is driven whether or not pc_next is high; the PC ignores it when pc_next=0.
- Redirect while stalled:
  - No latching is needed, because the frozen pipeline holds the request inputs stable.
  - pc_next stays low and PCSrc keeps showing the pending source.
  - On the release cycle there is exactly one pc_next pulse with that PCSrc.
- Flushes:
  - flush_ifid = pc_next and PCSrc != PC_4.
  - flush_idex = pc_next and (PCSrc = PC_JR or PC_BR).
  - Flushes are never asserted without pc_next.
- iREN = 1 in FETCH and IWAIT.
- Counters:
  - stall_cnt increments in every FETCH/IWAIT cycle with pc_next=0.
  - redirect_cnt increments on every pc_next with PCSrc != PC_4.
  - Both saturate at all-ones and never wrap.
  - A reset asserted mid-stall or mid-redirect clears them on that edge.

Decomposition:
- diaosi_types_pkg holds PCSrc_t (the 2-bit encoding above) and fetch_state_t (BOOT, FETCH, IWAIT, HALT).
- One sub-module, sat_counter: parameterised width, inc and synchronous clear. It is instantiated twice.
- The FSM and the arbitration stay inline in pc_fetch_ctrl.

Test Plan:
1. rst=1 for 2 cycles, then ihit=1 -> cycle 0 after reset: BOOT with iREN=0, pc_next=0. From cycle 1: pc_next=1 every cycle, PCSrc=00, stall_cnt=0.
2. ihit=0 for 3 cycles with branch_taken=1 held -> state=IWAIT, pc_next=0, PCSrc=01 throughout, stall_cnt=3. When ihit=1: one pc_next with flush_ifid=1, flush_idex=1, redirect_cnt=1.
3. jr_req=1, branch_taken=1 and jump_req=1 in the same cycle with ihit=1 -> PCSrc=11, flush_ifid=1, flush_idex=1.
4. load_use_stall=1, ihit=1 -> pc_next=0. Add branch_taken=1 in the same cycle -> pc_next=1, PCSrc=01.
5. dmem_req=1, dhit=0 for 2 cycles, ihit=1 -> pc_next=0 and stall_cnt += 2. When dhit=1: pc_next=1.
6. halt=1 together with jump_req=1 -> pc_next=0. Next cycle: halted=1, iREN=0. Later ihit or redirect inputs -> no output change and counters frozen until rst=1.
